// File: rtl/tpiu_trace_tx.sv
// Continuous-mode TPIU trace transmitter: packs (ID, byte) pairs into 16-byte frames
// and drives them one nibble per clock, with full and halfword synchronization.
module tpiu_trace_tx #(
  parameter int pFSYNC_FRAMES = 32
) (
  input  logic       trace_clk,
  input  logic       reset,
  input  logic [7:0] I_data,
  input  logic [6:0] I_id,
  input  logic       I_valid,
  output logic       O_ready,
  output logic [3:0] O_trace_data,
  output logic       O_frame_start,
  output logic       O_sync
);

  localparam int            CW       = (pFSYNC_FRAMES > 0) ? $clog2(pFSYNC_FRAMES + 1) : 1;
  localparam logic [CW-1:0] FSYNC_N  = CW'(pFSYNC_FRAMES);
  localparam bit            FSYNC_EN = (pFSYNC_FRAMES > 0);

  typedef enum logic [1:0] {
    ST_FSYNC = 2'd0,
    ST_HSYNC = 2'd1,
    ST_FRAME = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    trace_q, trace_d;
  logic          fs_q, fs_d;
  logic          sync_q, sync_d;
  logic [1:0]    n_q, n_d;
  logic [6:0]    b0_id_q, b0_id_d, b1_id_q, b1_id_d;
  logic [7:0]    b0_dat_q, b0_dat_d, b1_dat_q, b1_dat_d;
  logic [6:0]    cur_q, cur_d;
  logic [7:0]    aux_q, aux_d;
  logic [7:0]    odd_q, odd_d;
  logic [3:0]    hold_q, hold_d;

  logic       seg_last, fsync_enter, even_pt, slot14, have0, full, id_ok, push;
  logic [1:0] consume, m;
  logic [7:0] dec_byte, dec_odd;
  logic       dec_aux;
  logic [1:0] dec_consume;
  logic [6:0] dec_cur;

  // Handshake: a byte transfers on any edge where I_valid and O_ready are both high;
  // O_ready depends only on registered occupancy, so it never reacts to I_valid.
  assign O_ready       = (n_q != 2'd2);
  assign O_trace_data  = trace_q;
  assign O_frame_start = fs_q;
  assign O_sync        = sync_q;

  always_ff @(posedge trace_clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FSYNC;
      idx_q    <= 5'd0;
      cnt_q    <= '0;
      trace_q  <= 4'h0;
      fs_q     <= 1'b0;
      sync_q   <= 1'b0;
      n_q      <= 2'd0;
      b0_id_q  <= 7'd0;
      b0_dat_q <= 8'd0;
      b1_id_q  <= 7'd0;
      b1_dat_q <= 8'd0;
      cur_q    <= 7'd0;
      aux_q    <= 8'd0;
      odd_q    <= 8'd0;
      hold_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      trace_q  <= trace_d;
      fs_q     <= fs_d;
      sync_q   <= sync_d;
      n_q      <= n_d;
      b0_id_q  <= b0_id_d;
      b0_dat_q <= b0_dat_d;
      b1_id_q  <= b1_id_d;
      b1_dat_q <= b1_dat_d;
      cur_q    <= cur_d;
      aux_q    <= aux_d;
      odd_q    <= odd_d;
      hold_q   <= hold_d;
    end
  end

  // Next state: boundary priority is full sync, then halfword sync when empty, then frame.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q + 5'd1;
    cnt_d       = cnt_q;
    fsync_enter = 1'b0;
    seg_last    = ((state_q == ST_FSYNC) && (idx_q == 5'd7)) ||
                  ((state_q == ST_HSYNC) && (idx_q == 5'd3)) ||
                  ((state_q == ST_FRAME) && (idx_q == 5'd31));
    if (seg_last) begin
      idx_d = 5'd0;
      if (FSYNC_EN && (cnt_q == FSYNC_N)) begin
        state_d     = ST_FSYNC;
        cnt_d       = '0;
        fsync_enter = 1'b1;
      end else if (n_q == 2'd0) begin
        state_d = ST_HSYNC;
      end else begin
        state_d = ST_FRAME;
        if (FSYNC_EN) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Slot decision; the default covers the empty-buffer padding case.
  always_comb begin
    slot14      = (idx_q[4:2] == 3'd7);
    have0       = (n_q != 2'd0);
    full        = (n_q == 2'd2);
    dec_byte    = (cur_q == 7'd0) ? 8'h00 : 8'h01;
    dec_aux     = 1'b0;
    dec_odd     = 8'h00;
    dec_consume = 2'd0;
    dec_cur     = 7'd0;
    if (!slot14) begin
      if (have0 && (b0_id_q != cur_q)) begin
        dec_byte = {b0_id_q, 1'b1};
        dec_odd = b0_dat_q;
        dec_consume = 2'd1;
        dec_cur = b0_id_q;
      end else if (full && (b1_id_q == cur_q)) begin
        dec_byte = {b0_dat_q[7:1], 1'b0};
        dec_aux = b0_dat_q[0];
        dec_odd = b1_dat_q;
        dec_consume = 2'd2;
        dec_cur = cur_q;
      end else if (full) begin
        dec_byte = {b1_id_q, 1'b1};
        dec_aux = 1'b1;
        dec_odd = b0_dat_q;
        dec_consume = 2'd1;
        dec_cur = b1_id_q;
      end else if (have0) begin
        dec_byte = 8'h01;
        dec_aux = 1'b1;
        dec_odd = b0_dat_q;
        dec_consume = 2'd1;
        dec_cur = 7'd0;
      end
    end else begin
      if (have0 && (b0_id_q == cur_q)) begin
        dec_byte = {b0_dat_q[7:1], 1'b0};
        dec_aux = b0_dat_q[0];
        dec_consume = 2'd1;
        dec_cur = cur_q;
      end else if (have0) begin
        dec_byte = {b0_id_q, 1'b1};
        dec_cur = b0_id_q;
      end
    end
  end

  // Output nibble and frame datapath.
  always_comb begin
    trace_d = 4'h0;
    fs_d    = 1'b0;
    sync_d  = 1'b0;
    hold_d  = hold_q;
    odd_d   = odd_q;
    aux_d   = aux_q;
    even_pt = (state_q == ST_FRAME) && (idx_q[1:0] == 2'b00);
    consume = even_pt ? dec_consume : 2'd0;
    cur_d   = fsync_enter ? 7'd0 : (even_pt ? dec_cur : cur_q);
    case (state_q)
      ST_FSYNC: begin
        trace_d = (idx_q == 5'd7) ? 4'h7 : 4'hF;
        sync_d  = 1'b1;
      end
      ST_HSYNC: begin
        trace_d = (idx_q == 5'd3) ? 4'h7 : 4'hF;
        sync_d  = 1'b1;
      end
      ST_FRAME: begin
        fs_d = (idx_q == 5'd0);
        if (idx_q[0]) begin
          trace_d = hold_q;
        end else if (idx_q == 5'd30) begin
          trace_d = aux_q[3:0];
          hold_d  = aux_q[7:4];
        end else if (idx_q[1]) begin
          trace_d = odd_q[3:0];
          hold_d  = odd_q[7:4];
        end else begin
          trace_d = dec_byte[3:0];
          hold_d  = dec_byte[7:4];
          odd_d   = dec_odd;
          aux_d   = (idx_q == 5'd0) ? 8'h00 : aux_q;
          aux_d[idx_q[4:2]] = dec_aux;
        end
      end
      default: ;
    endcase
  end

  // Input buffer: consume first, then append; reserved IDs are accepted but dropped.
  always_comb begin
    id_ok    = (I_id != 7'd0) && (I_id[6:4] != 3'b111);
    push     = I_valid && O_ready && id_ok;
    b0_id_d  = b0_id_q;
    b0_dat_d = b0_dat_q;
    b1_id_d  = b1_id_q;
    b1_dat_d = b1_dat_q;
    case (consume)
      2'd1: begin
        b0_id_d  = b1_id_q;
        b0_dat_d = b1_dat_q;
        m        = n_q - 2'd1;
      end
      2'd2:    m = 2'd0;
      default: m = n_q;
    endcase
    if (push) begin
      if (m == 2'd0) begin
        b0_id_d  = I_id;
        b0_dat_d = I_data;
      end else begin
        b1_id_d  = I_id;
        b1_dat_d = I_data;
      end
    end
    n_d = m + {1'b0, push};
  end

endmodule

// File: tb/tb_tpiu_trace_tx.sv
// Directed bench for tpiu_trace_tx: sync patterns, frame formatting, ID switching,
// periodic full sync, reserved-ID discard and mid-frame reset.
`timescale 1ns/1ps
module tb_tpiu_trace_tx;

  logic       trace_clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] I_data = 8'h00;
  logic [6:0] I_id = 7'h00;
  logic       I_valid = 1'b0;
  logic       O_ready;
  logic [3:0] O_trace_data;
  logic       O_frame_start;
  logic       O_sync;

  int n_vec = 0;
  int n_miss = 0;
  logic [7:0] frame_b [16];

  logic [7:0] exp_t2 [16] = '{8'h03, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_t3 [16] = '{8'h07, 8'h55, 8'h09, 8'h10, 8'h20, 8'h33, 8'h01, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06};
  logic [7:0] exp_f1 [16] = '{8'h0B, 8'h00, 8'h00, 8'h02, 8'h02, 8'h04, 8'h04, 8'h06,
                              8'h06, 8'h08, 8'h08, 8'h0A, 8'h0A, 8'h0C, 8'h0C, 8'hFE};
  logic [7:0] exp_f2 [16] = '{8'h0E, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                              8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h00};
  logic [7:0] exp_f3 [16] = '{8'h0B, 8'h1D, 8'h1E, 8'h1F, 8'h20, 8'h21, 8'h22, 8'h23,
                              8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29, 8'h2A, 8'h00};

  always #5 trace_clk = ~trace_clk;

  tpiu_trace_tx #(.pFSYNC_FRAMES(2)) dut (
    .trace_clk    (trace_clk),
    .reset        (reset),
    .I_data       (I_data),
    .I_id         (I_id),
    .I_valid      (I_valid),
    .O_ready      (O_ready),
    .O_trace_data (O_trace_data),
    .O_frame_start(O_frame_start),
    .O_sync       (O_sync)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge trace_clk);
    #1;
  endtask

  task automatic send(input logic [6:0] id, input logic [7:0] d, output int waits);
    waits   = 0;
    I_valid = 1'b1;
    I_id    = id;
    I_data  = d;
    while (!O_ready && waits < 100) begin
      step();
      waits++;
    end
    check("send_ready", 32'(O_ready), 32'd1);
    step();
    I_valid = 1'b0;
  endtask

  task automatic check_sync_seq(input string tag);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("%s_nib%0d", tag, i), 32'(O_trace_data), (i == 7) ? 32'h7 : 32'hF);
      check($sformatf("%s_sync%0d", tag, i), 32'(O_sync), 32'd1);
    end
  endtask

  // Waits for the next frame start, counts sync nibbles seen before it, then gathers 32 nibbles.
  task automatic capture_frame(input string tag, output int syncs);
    int t;
    int bad;
    t = 0;
    bad = 0;
    syncs = 0;
    step();
    while (!O_frame_start && t < 200) begin
      if (O_sync) syncs++;
      step();
      t++;
    end
    check({tag, "_start"}, 32'(O_frame_start), 32'd1);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) begin
        step();
        if (O_frame_start || O_sync) bad++;
      end
      frame_b[i/2][(i%2)*4 +: 4] = O_trace_data;
    end
    check({tag, "_clean"}, 32'(bad), 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp [16]);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(frame_b[i]), 32'(exp[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, s, fs_cnt, t;

    repeat (3) @(posedge trace_clk);
    #1;
    check("rst_data", 32'(O_trace_data), 32'h0);
    check("rst_ready", 32'(O_ready), 32'd1);
    check("rst_fs", 32'(O_frame_start), 32'd0);
    check("rst_sync", 32'(O_sync), 32'd0);
    reset = 1'b0;

    check_sync_seq("fsync0");
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("hsync_nib%0d", i), 32'(O_trace_data), (i % 4 == 3) ? 32'h7 : 32'hF);
      check($sformatf("hsync_fs%0d", i), 32'(O_frame_start), 32'd0);
    end

    fork
      send(7'h01, 8'hA5, w);
      capture_frame("t2", s);
    join
    check_frame("t2", exp_t2);

    fork
      begin
        send(7'h03, 8'h55, w);
        send(7'h03, 8'h10, w);
        send(7'h04, 8'h21, w);
        send(7'h04, 8'h33, w);
      end
      capture_frame("t3", s);
    join
    check_frame("t3", exp_t3);

    fork
      begin
        for (int i = 0; i < 43; i++) send(7'h05, 8'(i), w);
      end
      begin
        capture_frame("f1", s);
        check("f1_syncs", 32'(s), 32'd8);
        check_frame("f1", exp_f1);
        capture_frame("f2", s);
        check("f2_syncs", 32'(s), 32'd0);
        check_frame("f2", exp_f2);
        capture_frame("f3", s);
        check("f3_syncs", 32'(s), 32'd8);
        check_frame("f3", exp_f3);
      end
    join

    send(7'h7F, 8'h12, w);
    check("disc7f_wait", 32'(w), 32'd0);
    send(7'h00, 8'h34, w);
    check("disc00_wait", 32'(w), 32'd0);
    send(7'h70, 8'h56, w);
    check("disc70_wait", 32'(w), 32'd0);
    fs_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (O_frame_start) fs_cnt++;
    end
    check("disc_no_frame", 32'(fs_cnt), 32'd0);
    check("disc_sync", 32'(O_sync), 32'd1);

    send(7'h01, 8'h55, w);
    t = 0;
    while (!O_frame_start && t < 100) begin
      step();
      t++;
    end
    check("t6_start", 32'(O_frame_start), 32'd1);
    repeat (17) step();
    reset = 1'b1;
    #1;
    check("t6_rst_data", 32'(O_trace_data), 32'h0);
    check("t6_rst_ready", 32'(O_ready), 32'd1);
    check("t6_rst_fs", 32'(O_frame_start), 32'd0);
    check("t6_rst_sync", 32'(O_sync), 32'd0);
    @(posedge trace_clk);
    #1;
    reset = 1'b0;
    check_sync_seq("fsync1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
